// File: rtl/keep_packing_resizer.sv
// -----------------------------------------------------------------------------
// keep_packing_resizer
//
// Stream width converter. It takes beats of S_KEEP_WIDTH lanes with any keep
// pattern and writes the kept lanes, compacted and in ascending lane order,
// into a circular lane FIFO. It then emits dense beats of M_KEEP_WIDTH lanes.
// A packet's final beat may be partial. Packet boundaries are preserved
// because input is stalled while a packet end is pending in the FIFO.
//
// Optional feature: define RESIZER_STATS_EN to add the packet and beat
// counters pkt_cnt_o and beat_cnt_o. With it undefined, those ports and
// counters do not exist.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   s_valid_i   in   input beat valid
//   s_last_i    in   input beat closes the packet
//   s_keep_i    in   [S_KEEP_WIDTH] lane enables, any pattern
//   s_data_i    in   [T_DATA_WIDTH] x [S_KEEP_WIDTH] lane data
//   s_ready_o   out  input beat accepted when s_valid_i & s_ready_o
//   m_valid_o   out  output beat valid
//   m_ready_i   in   output beat consumed when m_valid_o & m_ready_i
//   m_last_o    out  output beat closes the packet
//   m_keep_o    out  [M_KEEP_WIDTH] thermometer keep, contiguous from lane 0
//   m_data_o    out  [T_DATA_WIDTH] x [M_KEEP_WIDTH] lane data, unkept lanes 0
//   drop_o      out  1-cycle pulse after an accepted keep==0, last==0 beat
//   pkt_cnt_o   out  [31:0] packets emitted (RESIZER_STATS_EN only)
//   beat_cnt_o  out  [31:0] beats emitted   (RESIZER_STATS_EN only)
// -----------------------------------------------------------------------------
module keep_packing_resizer #(
  parameter int unsigned S_KEEP_WIDTH = 2,
  parameter int unsigned M_KEEP_WIDTH = 3,
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned BUF_LANES    = 2 * (S_KEEP_WIDTH + M_KEEP_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid_i,
  input  logic                    s_last_i,
  input  logic [S_KEEP_WIDTH-1:0] s_keep_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [S_KEEP_WIDTH],
  output logic                    s_ready_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o,
  output logic [M_KEEP_WIDTH-1:0] m_keep_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [M_KEEP_WIDTH],
  output logic                    drop_o
`ifdef RESIZER_STATS_EN
  ,
  output logic [31:0]             pkt_cnt_o,
  output logic [31:0]             beat_cnt_o
`endif
);

  localparam int unsigned PTR_W  = (BUF_LANES > 1) ? $clog2(BUF_LANES) : 1;
  localparam int unsigned FILL_W = $clog2(BUF_LANES + 1);

  if (BUF_LANES < S_KEEP_WIDTH + M_KEEP_WIDTH - 1) begin : g_buf_check
    $error("keep_packing_resizer: BUF_LANES must be >= S_KEEP_WIDTH + M_KEEP_WIDTH - 1");
  end

  // FILL: no packet end buffered, only full beats go out.
  // FLUSH: a packet end is buffered, drain up to it and mark the final beat.
  typedef enum logic {ST_FILL, ST_FLUSH} state_t;

  state_t                    state_q, state_d;
  logic [T_DATA_WIDTH-1:0]   lanes_q [BUF_LANES];
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  // Number of lanes from the head up to and including the packet's final lane.
  logic [FILL_W-1:0]         last_cnt_q, last_cnt_d;
  logic                      drop_q, drop_d;

  logic                      accept;
  logic                      pop;
  int unsigned               pop_n;
  int unsigned               push_n;
  int unsigned               offs [S_KEEP_WIDTH];

  // Circular index add. off never exceeds BUF_LANES, so one subtract is enough.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                input int unsigned      off);
    int unsigned sum;
    sum = 32'(ptr) + off;
    if (sum >= BUF_LANES) sum = sum - BUF_LANES;
    return PTR_W'(sum);
  endfunction

  // Compute all outputs and the next state from the registered state and the
  // current inputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that skips
    // an assignment would otherwise infer a latch.
    state_d    = state_q;
    last_cnt_d = last_cnt_q;
    m_valid_o  = 1'b0;
    m_last_o   = 1'b0;
    m_keep_o   = '0;
    pop_n      = 0;
    push_n     = 0;

    // Ready depends only on registered state. A pop in the same cycle gives no
    // credit, so there is no path from m_ready_i to s_ready_o.
    s_ready_o = rst_n && (state_q == ST_FILL) &&
                (32'(fill_q) + S_KEEP_WIDTH <= BUF_LANES);
    accept    = s_valid_i && s_ready_o;

    // Compaction: each kept lane goes to wr_ptr + (number of kept lanes below it).
    for (int unsigned i = 0; i < S_KEEP_WIDTH; i++) begin
      offs[i] = push_n;
      if (s_keep_i[i]) push_n = push_n + 1;
    end
    if (!accept) push_n = 0;

    // Form the head beat. When a packet end is pending, the beat is valid even
    // with zero lanes: that case is a null-last packet.
    if (state_q == ST_FLUSH) begin
      m_valid_o = 1'b1;
      pop_n     = (32'(last_cnt_q) < M_KEEP_WIDTH) ? 32'(last_cnt_q) : M_KEEP_WIDTH;
      m_last_o  = (pop_n == 32'(last_cnt_q));
    end else if (32'(fill_q) >= M_KEEP_WIDTH) begin
      m_valid_o = 1'b1;
      pop_n     = M_KEEP_WIDTH;
    end

    for (int unsigned j = 0; j < M_KEEP_WIDTH; j++) begin
      m_keep_o[j] = (j < pop_n);
      m_data_o[j] = (j < pop_n) ? lanes_q[wrap_add(rd_ptr_q, j)] : '0;
    end

    pop = m_valid_o && m_ready_i;

    fill_d   = FILL_W'(32'(fill_q) - (pop ? pop_n : 0) + push_n);
    rd_ptr_d = pop ? wrap_add(rd_ptr_q, pop_n) : rd_ptr_q;
    wr_ptr_d = wrap_add(wr_ptr_q, push_n);
    drop_d   = accept && (s_keep_i == '0) && !s_last_i;

    // An accept only happens in FILL, so it never coincides with the final pop.
    if (accept && s_last_i) begin
      state_d    = ST_FLUSH;
      last_cnt_d = fill_d;
    end else if (pop && state_q == ST_FLUSH) begin
      last_cnt_d = FILL_W'(32'(last_cnt_q) - pop_n);
      if (m_last_o) state_d = ST_FILL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      last_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      last_cnt_q <= last_cnt_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: lane storage has no reset. fill_q and the pointers decide which
  // entries are live, and unused lanes are masked to zero on the output.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < S_KEEP_WIDTH; i++) begin
      if (accept && s_keep_i[i]) lanes_q[wrap_add(wr_ptr_q, offs[i])] <= s_data_i[i];
    end
  end

  assign drop_o = drop_q;

`ifdef RESIZER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_o  <= '0;
      beat_cnt_o <= '0;
    end else if (pop) begin
      beat_cnt_o <= beat_cnt_o + 32'd1;
      if (m_last_o) pkt_cnt_o <= pkt_cnt_o + 32'd1;
    end
  end
`endif

endmodule
